// File: rtl/parser_seg_gather.sv
// Gathers up to C_NUM_SEGS beats of an AXI-Stream packet into one wide segment bundle.
// Define PARSER_SEG_VLAN_EN to extract the beat-0 VLAN ID; otherwise vlan/vlan_valid tie to 0.
module parser_seg_gather #(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_NUM_SEGS         = 4,
    parameter int unsigned C_VLAN_OFFSET      = 116
) (
    input  logic                                      axis_clk,
    input  logic                                      aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]              s_axis_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]             s_axis_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]            s_axis_tkeep,
    input  logic                                      s_axis_tvalid,
    input  logic                                      s_axis_tlast,
    output logic                                      s_axis_tready,
    input  logic                                      segs_fifo_ready,
    output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]   tdata_segs,
    output logic [C_AXIS_TUSER_WIDTH-1:0]             tuser_1st,
    output logic [$clog2(C_NUM_SEGS+1)-1:0]           seg_cnt,
    output logic                                      segs_trunc,
    output logic                                      segs_valid,
    output logic [11:0]                               vlan,
    output logic                                      vlan_valid
);

    localparam int unsigned CntW = $clog2(C_NUM_SEGS + 1);
    localparam int unsigned W    = C_AXIS_DATA_WIDTH;
    localparam logic [CntW-1:0] NumSegs = CntW'(C_NUM_SEGS);

    typedef enum logic [1:0] {StIdle, StCollect, StOutput, StDrain} state_e;

    state_e                      state_q, state_d;
    logic [CntW-1:0]             cnt_q, cnt_d, cnt_inc;
    logic [C_NUM_SEGS*W-1:0]     segs_q, segs_d;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
    logic [CntW-1:0]             seg_cnt_q, seg_cnt_d;
    logic                        trunc_q, trunc_d;
    logic                        segs_valid_q, segs_valid_d;
    logic                        accept, gathering, closing;
    logic                        unused_tkeep;

    assign unused_tkeep  = ^s_axis_tkeep;
    assign s_axis_tready = aresetn && (state_q != StOutput);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        segs_d       = segs_q;
        tuser_d      = tuser_q;
        seg_cnt_d    = seg_cnt_q;
        trunc_d      = trunc_q;
        segs_valid_d = 1'b0;

        accept    = s_axis_tvalid && s_axis_tready;
        gathering = (state_q == StIdle) || (state_q == StCollect);
        cnt_inc   = (state_q == StIdle) ? CntW'(1) : cnt_q + CntW'(1);
        // A bundle closes on tlast or once every slice is filled.
        closing   = accept && gathering && (s_axis_tlast || (cnt_inc == NumSegs));

        unique case (state_q)
            StIdle, StCollect: begin
                if (accept) begin
                    if (state_q == StIdle) begin
                        segs_d        = '0;
                        segs_d[0 +: W] = s_axis_tdata;
                        tuser_d       = s_axis_tuser;
                    end else begin
                        for (int k = 0; k < int'(C_NUM_SEGS); k++) begin
                            if (cnt_q == CntW'(k)) begin
                                segs_d[k*W +: W] = s_axis_tdata;
                            end
                        end
                    end
                    cnt_d = cnt_inc;
                    if (closing) begin
                        seg_cnt_d = cnt_inc;
                        trunc_d   = !s_axis_tlast;
                        if (segs_fifo_ready) begin
                            segs_valid_d = 1'b1;
                            state_d      = s_axis_tlast ? StIdle : StDrain;
                        end else begin
                            state_d = StOutput;
                        end
                    end else begin
                        state_d = StCollect;
                    end
                end
            end
            StOutput: begin
                if (segs_fifo_ready) begin
                    segs_valid_d = 1'b1;
                    state_d      = trunc_q ? StDrain : StIdle;
                end
            end
            StDrain: begin
                if (accept && s_axis_tlast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            segs_q       <= '0;
            tuser_q      <= '0;
            seg_cnt_q    <= '0;
            trunc_q      <= 1'b0;
            segs_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            segs_q       <= segs_d;
            tuser_q      <= tuser_d;
            seg_cnt_q    <= seg_cnt_d;
            trunc_q      <= trunc_d;
            segs_valid_q <= segs_valid_d;
        end
    end

    assign tdata_segs = segs_q;
    assign tuser_1st  = tuser_q;
    assign seg_cnt    = seg_cnt_q;
    assign segs_trunc = trunc_q;
    assign segs_valid = segs_valid_q;

`ifdef PARSER_SEG_VLAN_EN
    logic [11:0] vlan_q;
    logic        vlan_valid_q;

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            vlan_q       <= '0;
            vlan_valid_q <= 1'b0;
        end else begin
            vlan_valid_q <= accept && (state_q == StIdle);
            if (accept && (state_q == StIdle)) begin
                vlan_q <= s_axis_tdata[C_VLAN_OFFSET +: 12];
            end
        end
    end

    assign vlan       = vlan_q;
    assign vlan_valid = vlan_valid_q;
`else
    assign vlan       = '0;
    assign vlan_valid = 1'b0;
`endif

endmodule

// File: tb/tb_parser_seg_gather.sv
// Randomized bench for parser_seg_gather against a packet-level reference model.
// Expects vlan extraction only when PARSER_SEG_VLAN_EN is defined for the build.
module tb_parser_seg_gather;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int NS = 4;
    localparam int VO = 116;
    localparam int CW = $clog2(NS + 1);
    localparam int KW = DW / 8;
    localparam int NPKT = 40;

    logic              axis_clk;
    logic              aresetn;
    logic [DW-1:0]     s_axis_tdata;
    logic [UW-1:0]     s_axis_tuser;
    logic [KW-1:0]     s_axis_tkeep;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;
    logic              segs_fifo_ready;
    logic [NS*DW-1:0]  tdata_segs;
    logic [UW-1:0]     tuser_1st;
    logic [CW-1:0]     seg_cnt;
    logic              segs_trunc;
    logic              segs_valid;
    logic [11:0]       vlan;
    logic              vlan_valid;

    parser_seg_gather #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .C_NUM_SEGS        (NS),
        .C_VLAN_OFFSET     (VO)
    ) dut (
        .axis_clk       (axis_clk),
        .aresetn        (aresetn),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .segs_fifo_ready(segs_fifo_ready),
        .tdata_segs     (tdata_segs),
        .tuser_1st      (tuser_1st),
        .seg_cnt        (seg_cnt),
        .segs_trunc     (segs_trunc),
        .segs_valid     (segs_valid),
        .vlan           (vlan),
        .vlan_valid     (vlan_valid)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: what each output should show after the coming edge.
    logic [DW-1:0] m_slice [NS];
    logic [UW-1:0] m_user;
    logic [CW-1:0] m_cnt;
    logic          m_trunc;
    logic          m_sv;
    logic [11:0]   m_vlan;
    logic          m_vlan_valid;
    logic          m_pending;

    // Stimulus state.
    int            pkt_len;
    int            beat_i;
    logic          pkt_done;
    logic [DW-1:0] cur_data;
    logic [UW-1:0] cur_user;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [UW-1:0] rand_user();
        logic [UW-1:0] r;
        for (int i = 0; i < UW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NS; k++) m_slice[k] = '0;
        m_user = '0; m_cnt = '0; m_trunc = 1'b0; m_sv = 1'b0;
        m_vlan = '0; m_vlan_valid = 1'b0; m_pending = 1'b0;
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NS; k++) begin
            check($sformatf("slice%0d", k), tdata_segs[k*DW +: DW], m_slice[k]);
        end
        check("tuser_1st", DW'(tuser_1st), DW'(m_user));
        check("seg_cnt", DW'(seg_cnt), DW'(m_cnt));
        check("segs_trunc", DW'(segs_trunc), DW'(m_trunc));
        check("segs_valid", DW'(segs_valid), DW'(m_sv));
        check("vlan", DW'(vlan), DW'(m_vlan));
        check("vlan_valid", DW'(vlan_valid), DW'(m_vlan_valid));
    endtask

    // One clock: check last edge's results, drive inputs, predict the next edge.
    task automatic cycle(input bit force_rdy, input bit hold_low, input bit vld_en);
        logic exp_tready;
        logic acc;
        int   nclose;
        check_outputs();
        s_axis_tvalid   = vld_en && ($urandom_range(3) != 0);
        segs_fifo_ready = hold_low ? 1'b0 : (force_rdy ? 1'b1 : ($urandom_range(2) != 0));
        s_axis_tdata    = cur_data;
        s_axis_tuser    = cur_user;
        s_axis_tlast    = (beat_i == pkt_len - 1);
        s_axis_tkeep    = KW'($urandom);
        exp_tready      = !m_pending;
        #1;
        check("tready", DW'(s_axis_tready), DW'(exp_tready));
        acc    = s_axis_tvalid && exp_tready;
        nclose = (pkt_len < NS) ? pkt_len : NS;
        m_sv         = 1'b0;
        m_vlan_valid = 1'b0;
        if (acc) begin
            if (beat_i == 0) begin
                for (int k = 0; k < NS; k++) m_slice[k] = '0;
                m_slice[0] = cur_data;
                m_user     = cur_user;
`ifdef PARSER_SEG_VLAN_EN
                m_vlan       = cur_data[VO +: 12];
                m_vlan_valid = 1'b1;
`endif
            end else if (beat_i < NS) begin
                m_slice[beat_i] = cur_data;
            end
            if (beat_i == nclose - 1) begin
                m_cnt   = CW'(nclose);
                m_trunc = (pkt_len > NS);
                if (segs_fifo_ready) m_sv = 1'b1;
                else                 m_pending = 1'b1;
            end
            beat_i++;
            if (beat_i == pkt_len) pkt_done = 1'b1;
            cur_data = rand_data();
            cur_user = rand_user();
        end else if (m_pending && segs_fifo_ready) begin
            m_sv      = 1'b1;
            m_pending = 1'b0;
        end
        @(negedge axis_clk);
    endtask

    initial begin
        int guard;
        bit force_rdy;
        bit hold;
        aresetn         = 1'b0;
        s_axis_tdata    = '0;
        s_axis_tuser    = '0;
        s_axis_tkeep    = '0;
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        segs_fifo_ready = 1'b0;
        pkt_len  = 1;
        beat_i   = 0;
        pkt_done = 1'b0;
        cur_data = rand_data();
        cur_user = rand_user();
        model_reset();
        repeat (2) @(negedge axis_clk);
        check_outputs();
        check("tready_in_reset", DW'(s_axis_tready), '0);
        aresetn = 1'b1;

        for (int p = 0; p < NPKT; p++) begin
            case (p)
                0: pkt_len = 2;
                1: pkt_len = 1;
                2: pkt_len = 6;
                3: pkt_len = 3;
                4: pkt_len = 3;
                5: pkt_len = 3;
                default: pkt_len = $urandom_range(1, 9);
            endcase
            force_rdy = (p <= 2) || (p == 4) || (p == 5);
            hold      = (p == 3);
            beat_i    = 0;
            pkt_done  = 1'b0;
            cur_data  = rand_data();
            cur_user  = rand_user();
            if (p == 0) cur_data[VO +: 12] = 12'h123;
            guard = 0;
            while (!pkt_done && !(p == 5 && beat_i == 2)) begin
                cycle(force_rdy, hold, 1'b1);
                guard++;
                if (guard > 300) begin
                    check("pkt_timeout", DW'(1), '0);
                    break;
                end
            end
            if (p == 3) begin
                repeat (5) cycle(1'b0, 1'b1, 1'b0);
            end
            if (p == 5) begin
                aresetn = 1'b0;
                #1;
                model_reset();
                check_outputs();
                check("tready_mid_reset", DW'(s_axis_tready), '0);
                repeat (2) @(negedge axis_clk);
                aresetn = 1'b1;
            end
        end
        repeat (4) cycle(1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parser_seg_gather.md
PARSER_SEG_GATHER -- requirements
Module: parser_seg_gather

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256, beat width in bits.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128, tuser width.
REQ-003 SHALL have parameter C_NUM_SEGS, default 4, legal 1..8, max segments gathered per packet.
REQ-004 SHALL have parameter C_VLAN_OFFSET, default 116, LSB of the 12-bit VLAN ID in beat 0.
REQ-005 SHALL have one clock and an asynchronous, active-low reset:
- axis_clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
REQ-006 SHALL have these data and control ports:
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  beat data
- s_axis_tuser  in  C_AXIS_TUSER_WIDTH  beat metadata
- s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  byte enables, ignored
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last beat of packet
- s_axis_tready  out  1  beat accepted when tvalid&&tready
- segs_fifo_ready  in  1  downstream can take a segment bundle
- tdata_segs  out  C_NUM_SEGS*C_AXIS_DATA_WIDTH  gathered beats, beat k at slice k
- tuser_1st  out  C_AXIS_TUSER_WIDTH  tuser of beat 0
- seg_cnt  out  $clog2(C_NUM_SEGS+1)  number of valid slices
- segs_trunc  out  1  packet longer than C_NUM_SEGS beats
- segs_valid  out  1  one-cycle bundle strobe
- vlan  out  12  VLAN ID of beat 0
- vlan_valid  out  1  one-cycle VLAN strobe

Function
REQ-007 SHALL implement states IDLE, COLLECT, OUTPUT and DRAIN.
REQ-008 SHALL drive s_axis_tready=1 in IDLE, COLLECT and DRAIN, and 0 in OUTPUT.
REQ-009 On an accepted beat in IDLE, SHALL store the beat in slice 0, latch tuser_1st, zero slices 1..C_NUM_SEGS-1 and set the internal count to 1.
REQ-010 On an accepted beat in COLLECT, SHALL store the beat at slice count and increment the count; older slices are not altered.
REQ-011 A beat is "closing" if it is accepted in IDLE or COLLECT and either tlast=1 or count reaches C_NUM_SEGS.
REQ-012 On a closing beat, SHALL register seg_cnt, and SHALL set segs_trunc=1 only when tlast=0.
REQ-013 On a closing beat with segs_fifo_ready=1, SHALL pulse segs_valid on the next cycle and go to DRAIN if truncated, otherwise IDLE.
REQ-014 On a closing beat with segs_fifo_ready=0, SHALL go to OUTPUT.
REQ-015 In OUTPUT, SHALL hold tdata_segs, tuser_1st, seg_cnt and segs_trunc.
REQ-016 In OUTPUT, when segs_fifo_ready=1, SHALL pulse segs_valid on the next cycle and go to DRAIN if truncated, otherwise IDLE.
REQ-017 A non-closing beat in IDLE or COLLECT SHALL move the block to COLLECT.
REQ-018 In DRAIN, SHALL discard accepted beats without storing them, and return to IDLE on an accepted beat with tlast=1.
REQ-019 A single-beat packet (tlast on beat 0) SHALL be legal and yield seg_cnt=1.
REQ-020 SHALL set segs_valid=1 for exactly one cycle per packet, and never while an earlier bundle is pending.
REQ-021 tdata_segs, tuser_1st, seg_cnt and segs_trunc SHALL stay stable from the segs_valid cycle until the next beat is accepted in IDLE.
REQ-022 Latency SHALL be one cycle: from closing beat to segs_valid when ready, and from ready in OUTPUT to segs_valid.
REQ-023 SHALL hold vlan from the last accepted beat 0 until the next one.

Reset
REQ-024 While aresetn=0, SHALL force state=IDLE and zero tdata_segs, tuser_1st, seg_cnt, segs_trunc, segs_valid, vlan, vlan_valid and the count.
REQ-025 While aresetn=0, s_axis_tready SHALL be 0.
REQ-026 Reset asserted mid-packet SHALL discard the partial packet; the first accepted beat after release is treated as beat 0.

Configuration
REQ-027 With PARSER_SEG_VLAN_EN defined, an accepted beat in IDLE SHALL register vlan=s_axis_tdata[C_VLAN_OFFSET+:12] and pulse vlan_valid on the next cycle.
REQ-028 Without PARSER_SEG_VLAN_EN, vlan and vlan_valid SHALL be constant 0; the ports remain present.

Verification (C_NUM_SEGS=4, widths default, PARSER_SEG_VLAN_EN defined)
REQ-029 2-beat packet, beat0 VLAN field 0x123, segs_fifo_ready=1 -> vlan=0x123 with vlan_valid 1 cycle after beat0; segs_valid 1 cycle after beat1; seg_cnt=2; slices 2,3 zero; trunc=0.
REQ-030 1-beat packet with tlast -> segs_valid next cycle, seg_cnt=1, slices 1..3 zero.
REQ-031 6-beat packet, ready=1 -> segs_valid after beat3, seg_cnt=4, trunc=1; beats 4,5 consumed with tready=1; next packet's beat0 lands in slice 0.
REQ-032 3-beat packet, ready=0 for 5 cycles after tlast -> tready=0 and outputs held for 5 cycles; segs_valid exactly 1 cycle after ready rises.
REQ-033 aresetn dropped after beat 1 of 3 -> all outputs 0 immediately; the next packet is gathered from slice 0 with correct seg_cnt.
REQ-034 Rebuild without PARSER_SEG_VLAN_EN, rerun REQ-029 -> vlan=0 and vlan_valid never 1; segment outputs unchanged.
